// File: rtl/uart_pkg.sv
// Shared types and constants for the word-wide UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEF = 868;  // 100 MHz / 115200 baud
    localparam int FRAME_W          = 8;

endpackage

// File: rtl/uart_tx_word_if.sv
// Request/status bundle between a word source and uart_tx_word.
interface uart_tx_word_if #(
    parameter int W = 32
);
    logic         start_i;
    logic [W-1:0] data_i;
    logic         tx_o;
    logic         busy_o;
    logic         done_o;

    modport master (output start_i, data_i, input tx_o, busy_o, done_o);
    modport slave  (input start_i, data_i, output tx_o, busy_o, done_o);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time counter: ticks on the last cycle of each bit, held at zero while disabled.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_word.sv
// Serializes a W-bit word as W/8 back-to-back 8N1 frames, least-significant byte first.
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int W            = 32,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    uart_tx_word_if.slave   bus
);
    localparam int NBYTES = W / FRAME_W;
    localparam int BIT_W  = $clog2(FRAME_W);
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    uart_state_t       state, state_n;
    logic [W-1:0]      shreg, shreg_n;
    logic [BIT_W-1:0]  bit_idx, bit_idx_n;
    logic [BYTE_W-1:0] byte_idx, byte_idx_n;
    logic              tx, tx_n;
    logic              done, done_n;
    logic              tick;
    logic              last_bit, last_byte;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (state != IDLE),
        .tick  (tick)
    );

    assign last_bit  = (bit_idx == BIT_W'(FRAME_W - 1));
    assign last_byte = (byte_idx == BYTE_W'(NBYTES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx       <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            tx       <= tx_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        done_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_i) begin
                    state_n    = START;
                    shreg_n    = bus.data_i;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                end
            end
            START: begin
                if (tick)
                    state_n = DATA;
            end
            DATA: begin
                if (tick) begin
                    // One shift per data bit, so the next byte lands in [7:0] after eight.
                    shreg_n   = {1'b0, shreg[W-1:1]};
                    bit_idx_n = last_bit ? '0 : bit_idx + 1'b1;
                    if (last_bit)
                        state_n = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    byte_idx_n = last_byte ? '0 : byte_idx + 1'b1;
                    state_n    = last_byte ? IDLE : START;
                    done_n     = last_byte;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line value is registered, so derive it from where the FSM is heading.
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    assign bus.tx_o   = tx;
    assign bus.busy_o = (state != IDLE);
    assign bus.done_o = done;
endmodule

// File: tb/tb_uart_tx_word.sv
// Directed checks of uart_tx_word with 4 clocks per bit and 32-bit words.
module tb_uart_tx_word;
    localparam int W     = 32;
    localparam int CPB   = 4;
    localparam int FRAME = CPB * 10;
    localparam int WORD  = FRAME * (W / 8);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_word_if #(.W(W)) bus ();
    uart_tx_word #(.W(W), .CLKS_PER_BIT(CPB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    logic txs [0:399];
    logic bss [0:399];
    logic dns [0:399];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference line value for sample k of a word whose first start bit is sample 0.
    function automatic logic frame_bit(input logic [31:0] w, input int k);
        int pos;
        if (k < 0 || k >= WORD) return 1'b1;
        pos = (k % FRAME) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return w[(k / FRAME) * 8 + pos - 1];
    endfunction

    function automatic int line_errs(input int base, input logic [31:0] w);
        int e = 0;
        for (int k = 0; k < WORD; k++)
            if (txs[base + k] !== frame_bit(w, k)) e++;
        return e;
    endfunction

    function automatic logic [31:0] decode(input int base);
        logic [31:0] w = '0;
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 8; j++)
                w[b*8 + j] = txs[base + b*FRAME + (1 + j)*CPB + 2];
        return w;
    endfunction

    function automatic int ones(input int sel, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i < hi; i++)
            case (sel)
                0: c += (txs[i] === 1'b0) ? 1 : 0;  // zeros on the line
                1: c += (bss[i] === 1'b1) ? 1 : 0;
                default: c += (dns[i] === 1'b1) ? 1 : 0;
            endcase
        return c;
    endfunction

    // Returns at the negedge of the first cycle after the accepting edge.
    task automatic kick(input logic [31:0] d);
        @(negedge clk);
        bus.data_i  = d;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Sample i is cycle i+1 after acceptance; inj raises start_i during that cycle.
    task automatic capture(input int n, input int inj, input logic [31:0] inj_d, input bit tog);
        for (int i = 0; i < n; i++) begin
            txs[i] = bus.tx_o;
            bss[i] = bus.busy_o;
            dns[i] = bus.done_o;
            if (i == inj) begin
                bus.data_i  = inj_d;
                bus.start_i = 1'b1;
            end else begin
                bus.start_i = 1'b0;
            end
            if (tog) bus.data_i = ~bus.data_i;
            @(negedge clk);
        end
        bus.start_i = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.data_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", bus.tx_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        rst = 1'b0;

        // Idle line with no requests
        capture(100, -1, 0, 0);
        chk("idle_tx_zeros", ones(0, 0, 100), 0);
        chk("idle_busy", ones(1, 0, 100), 0);
        chk("idle_done", ones(2, 0, 100), 0);

        // Basic word
        kick(32'h1234_5678);
        capture(170, -1, 0, 0);
        chk("basic_line", line_errs(0, 32'h1234_5678), 0);
        chk("basic_word", decode(0), 32'h1234_5678);
        chk("basic_busy_cnt", ones(1, 0, 170), 160);
        chk("basic_busy_last", bss[159], 1);
        chk("basic_done_cnt", ones(2, 0, 170), 1);
        chk("basic_done_at", dns[160], 1);

        // Start while busy is ignored
        kick(32'hC3A5_0F96);
        capture(170, 49, 32'hFFFF_FFFF, 0);
        chk("ign_line", line_errs(0, 32'hC3A5_0F96), 0);
        chk("ign_word", decode(0), 32'hC3A5_0F96);
        chk("ign_tail_zeros", ones(0, 160, 170), 0);
        chk("ign_busy_cnt", ones(1, 0, 170), 160);
        chk("ign_done_cnt", ones(2, 0, 170), 1);

        // Start in the done cycle chains immediately
        kick(32'h1234_5678);
        capture(330, 160, 32'hA5A5_A5A5, 0);
        chk("chain_line1", line_errs(0, 32'h1234_5678), 0);
        chk("chain_gap", txs[160], 1);
        chk("chain_line2", line_errs(161, 32'hA5A5_A5A5), 0);
        chk("chain_word2", decode(161), 32'hA5A5_A5A5);
        chk("chain_busy_cnt", ones(1, 0, 330), 320);
        chk("chain_done_cnt", ones(2, 0, 330), 2);
        chk("chain_done2_at", dns[321], 1);

        // Reset in mid-transfer at cycle 70
        kick(32'hFFFF_0000);
        repeat (69) @(negedge clk);
        chk("abort_tx_before", bus.tx_o, 0);
        rst = 1'b1;
        #1;
        chk("abort_tx", bus.tx_o, 1);
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_done", bus.done_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        capture(60, -1, 0, 0);
        chk("abort_idle_zeros", ones(0, 0, 60), 0);
        chk("abort_idle_busy", ones(1, 0, 60), 0);
        chk("abort_idle_done", ones(2, 0, 60), 0);
        kick(32'h5A3C_0FF1);
        capture(170, -1, 0, 0);
        chk("after_rst_line", line_errs(0, 32'h5A3C_0FF1), 0);
        chk("after_rst_word", decode(0), 32'h5A3C_0FF1);
        chk("after_rst_done", ones(2, 0, 170), 1);

        // data_i toggling after acceptance does not disturb the word
        kick(32'h0000_0001);
        capture(170, -1, 0, 1);
        chk("toggle_line", line_errs(0, 32'h0000_0001), 0);
        chk("toggle_word", decode(0), 32'h0000_0001);
        chk("toggle_done", ones(2, 0, 170), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
